// File: rtl/tcdm_arb_pkg.sv
// Shared types and constants for the TCDM bank arbiter: master index type,
// request bundle layout and index-width helper.
package tcdm_arb_pkg;

  localparam int N_MASTER_DEF   = 4;
  localparam int ADDR_WIDTH_DEF = 11;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int BE_WIDTH_DEF   = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam int MIDX_W = (N_MASTER_DEF > 1) ? $clog2(N_MASTER_DEF) : 1;

  typedef logic [MIDX_W-1:0] midx_t;

  typedef struct packed {
    logic                      ts_set;
    logic [ADDR_WIDTH_DEF-1:0] add;
    logic                      wen;
    logic [DATA_WIDTH_DEF-1:0] wdata;
    logic [BE_WIDTH_DEF-1:0]   be;
  } tcdm_req_t;

  // Index width for an arbitrary master count, used by parameterised instances.
  function automatic int calc_midx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcdm_arb_resp_fifo.sv
// In-order FIFO of granted master indices; the head owns the next bank response.
module tcdm_arb_resp_fifo
  import tcdm_arb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int IDX_W = MIDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [IDX_W-1:0] data_i,
  input  logic             pop_i,
  output logic [IDX_W-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [IDX_W-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one TCDM bank port between N_MASTER requesters,
// with in-order response routing. Optional master-0 priority: TCDM_ARB_HIPRIO_EN.
module tcdm_bank_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter int N_MASTER   = N_MASTER_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BE_WIDTH   = BE_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int IDX_W     = calc_midx_w(N_MASTER)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_MASTER-1:0]            req_i,
  input  logic [N_MASTER*ADDR_WIDTH-1:0] add_i,
  input  logic [N_MASTER-1:0]            wen_i,
  input  logic [N_MASTER*DATA_WIDTH-1:0] wdata_i,
  input  logic [N_MASTER*BE_WIDTH-1:0]   be_i,
  input  logic [N_MASTER-1:0]            ts_set_i,
  output logic [N_MASTER-1:0]            gnt_o,
  output logic [N_MASTER-1:0]            r_valid_o,
  output logic [DATA_WIDTH-1:0]          r_rdata_o,
  output logic                           bank_req_o,
  output logic [ADDR_WIDTH-1:0]          bank_add_o,
  output logic                           bank_wen_o,
  output logic [DATA_WIDTH-1:0]          bank_wdata_o,
  output logic [BE_WIDTH-1:0]            bank_be_o,
  output logic                           bank_ts_set_o,
  output logic [IDX_W-1:0]               bank_id_o,
  input  logic                           bank_gnt_i,
  input  logic                           bank_r_valid_i,
  input  logic [DATA_WIDTH-1:0]          bank_r_rdata_i,
  output logic                           resp_err_o
);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] head_idx;
  logic             resp_err_q, resp_err_d;
  logic             any_req, found, accept, pop;
  logic             fifo_full, fifo_empty;
  int               cand;

  assign any_req    = |req_i;
  assign bank_req_o = any_req & ~fifo_full;
  assign accept     = bank_req_o & bank_gnt_i;
  assign pop        = bank_r_valid_i & ~fifo_empty;
  assign bank_id_o  = bank_req_o ? win_idx : '0;
  assign resp_err_o = resp_err_q;

  // Cyclic search starting at rr_ptr; compare-and-subtract keeps non-power-of-two N correct.
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
`ifdef TCDM_ARB_HIPRIO_EN
    if (req_i[0]) begin
      found = 1'b1;
    end
    for (int off = 0; off < N_MASTER - 1; off++) begin
      cand = int'(rr_ptr_q) + off;
      if (cand >= N_MASTER) cand = cand - (N_MASTER - 1);
      if (!found && req_i[IDX_W'(cand)]) begin
        found   = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
`else
    for (int off = 0; off < N_MASTER; off++) begin
      cand = int'(rr_ptr_q) + off;
      if (cand >= N_MASTER) cand = cand - N_MASTER;
      if (!found && req_i[IDX_W'(cand)]) begin
        found   = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
`endif
  end

  always_comb begin
    bank_add_o    = '0;
    bank_wen_o    = 1'b0;
    bank_wdata_o  = '0;
    bank_be_o     = '0;
    bank_ts_set_o = 1'b0;
    gnt_o         = '0;
    r_valid_o     = '0;
    for (int m = 0; m < N_MASTER; m++) begin
      if (bank_req_o && (win_idx == IDX_W'(m))) begin
        bank_add_o    = add_i[m*ADDR_WIDTH +: ADDR_WIDTH];
        bank_wen_o    = wen_i[m];
        bank_wdata_o  = wdata_i[m*DATA_WIDTH +: DATA_WIDTH];
        bank_be_o     = be_i[m*BE_WIDTH +: BE_WIDTH];
        bank_ts_set_o = ts_set_i[m];
      end
      gnt_o[m]     = accept && (win_idx == IDX_W'(m));
      r_valid_o[m] = pop && (head_idx == IDX_W'(m));
    end
    r_rdata_o = pop ? bank_r_rdata_i : '0;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    resp_err_d = resp_err_q;
`ifdef TCDM_ARB_HIPRIO_EN
    if (accept && (win_idx != '0)) begin
      rr_ptr_d = (win_idx == IDX_W'(N_MASTER - 1)) ? IDX_W'(1) : win_idx + 1'b1;
    end
`else
    if (accept) begin
      rr_ptr_d = (win_idx == IDX_W'(N_MASTER - 1)) ? '0 : win_idx + 1'b1;
    end
`endif
    if (bank_r_valid_i && fifo_empty) resp_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef TCDM_ARB_HIPRIO_EN
      rr_ptr_q <= IDX_W'(1);
`else
      rr_ptr_q <= '0;
`endif
      resp_err_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      resp_err_q <= resp_err_d;
    end
  end

  tcdm_arb_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .IDX_W (IDX_W)
  ) u_resp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .data_i  (win_idx),
    .pop_i   (pop),
    .head_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: doc/tcdm_bank_arbiter.md
Name: tcdm_bank_arbiter

Overview:
- Shares one TCDM bank request port between N_MASTER requesters, using round-robin arbitration with one grant per cycle.
- Sits directly upstream of the bank's request pipeline stage (SCM/SRAM split stage). That stage may withhold its grant for 1–2 cycles after an SRAM access.
- Records the winner index of every accepted request in an in-order FIFO. Each bank response is routed back to the master that owns the head entry.

Parameters:
- N_MASTER, 4, number of requesters (≥2; need not be a power of two).
- ADDR_WIDTH, 11, bank address width; MSB selects SCM.
- DATA_WIDTH, 32, write/read data width.
- BE_WIDTH, 4, byte-enable width.
- FIFO_DEPTH, 4, maximum outstanding requests (power of two, ≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_i  in  N_MASTER  per-master request
- add_i  in  N_MASTER×ADDR_WIDTH  per-master address
- wen_i  in  N_MASTER  per-master type: 0 = store, 1 = load
- wdata_i  in  N_MASTER×DATA_WIDTH  per-master write data
- be_i  in  N_MASTER×BE_WIDTH  per-master byte enable
- ts_set_i  in  N_MASTER  per-master test&set SET flag
- gnt_o  out  N_MASTER  one-hot grant
- r_valid_o  out  N_MASTER  one-hot response valid
- r_rdata_o  out  DATA_WIDTH  response data, broadcast to all masters
- bank_req_o  out  1  request to the bank stage
- bank_add_o / bank_wen_o / bank_wdata_o / bank_be_o / bank_ts_set_o  out  matching widths  fields of the winning master
- bank_id_o  out  MIDX_W  winner index
- bank_gnt_i  in  1  grant from the bank stage
- bank_r_valid_i  in  1  bank response valid
- bank_r_rdata_i  in  DATA_WIDTH  bank response data
- resp_err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset values:
  - rr_ptr = 0; FIFO empty (count = 0); resp_err_o = 0.
  - All combinational outputs are 0 while req_i = 0 and bank_r_valid_i = 0.
- Arbitration (combinational, zero latency):
  - The winner w is the first index with req_i set, searching cyclically from rr_ptr.
  - bank_req_o = |req_i & ~full.
  - bank_* fields = fields of w. When bank_req_o = 0, the fields are 0.
  - gnt_o[w] = bank_req_o & bank_gnt_i. All other gnt_o bits are 0.
- Accept = bank_req_o & bank_gnt_i. On accept:
  - rr_ptr <= (w == N_MASTER-1) ? 0 : w+1, using explicit compare so non-power-of-two N wraps correctly.
  - Push w into the FIFO.
- No accept: rr_ptr holds, and a request held while bank_gnt_i = 0 keeps the same winner.
- Full (count == FIFO_DEPTH): bank_req_o is forced to 0 and no gnt_o is asserted. Masters keep their requests pending.
- Response path:
  - Every accepted request (load or store) yields exactly one bank_r_valid_i, in acceptance order, at least 1 cycle after its accept.
  - When bank_r_valid_i = 1 and the FIFO is not empty: r_valid_o[head] = 1, r_rdata_o = bank_r_rdata_i, and the head is popped.
  - When the FIFO is not empty and bank_r_valid_i = 0, r_rdata_o = 0.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, a pop frees a slot on the next cycle only; there is no same-cycle bypass.
- Protocol error: bank_r_valid_i with the FIFO empty sets resp_err_o = 1, asserts no r_valid_o bit, and changes no state. resp_err_o clears only on reset.
- Reset mid-operation: outstanding FIFO entries are discarded and rr_ptr returns to 0.

Optional Feature:
- Macro: TCDM_ARB_HIPRIO_EN.
- Defined: master 0 wins whenever req_i[0] = 1. The round-robin search covers indices 1..N_MASTER-1 only, and rr_ptr is not updated on a master-0 accept. rr_ptr ranges over 1..N_MASTER-1, with reset value 1.
- Undefined: plain round-robin over all masters, as described in Behaviour.

Decomposition:
- Package tcdm_arb_pkg holds:
  - Constant MIDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1.
  - Typedef midx_t.
  - Typedef of the packed request bundle struct {ts_set, add, wen, wdata, be}.
- Sub-module tcdm_arb_resp_fifo: synchronous FIFO of midx_t with push, pop, full, empty and head outputs, parameterised on FIFO_DEPTH.

Test Plan:
- Rotation: N = 4, req_i = 4'b1111 held, bank_gnt_i = 1 → grants in order 0, 1, 2, 3, 0 on consecutive cycles. Responses 1 cycle later return to masters 0, 1, 2, 3 in order with matching rdata.
- Stall: req_i = 4'b0100, bank_gnt_i = 0 for 2 cycles, then 1 → bank_req_o = 1 and bank_id_o = 2 throughout, gnt_o = 4'b0100 only in cycle 3, and rr_ptr becomes 3.
- Full: FIFO_DEPTH = 4, four accepts with no responses → 5th cycle has bank_req_o = 0 and gnt_o = 0. One response pops → the grant resumes on the following cycle.
- Wrap with N_MASTER = 3: rr_ptr = 2 and req_i = 3'b011 → winner 0, and rr_ptr becomes 1.
- Error: bank_r_valid_i pulsed with the FIFO empty after reset → r_valid_o = 0, resp_err_o = 1 and stays set until rst_n is asserted.
- With TCDM_ARB_HIPRIO_EN: req_i = 4'b1011 held → master 0 is granted every cycle, and masters 1 and 3 are never granted until req_i[0] drops.
